// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver
//
// Recovers frames of one start bit (0), DATA_BITS data bits sent LSB first and
// one stop bit (1) from an asynchronous serial line. The line is brought into
// the clk domain through a two-flop synchronizer. A single baud counter times
// the half-bit point of the start bit and then one full bit period for each
// following bit, so every bit is sampled near its centre.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rxd        in   serial input, asynchronous to clk, idle high
//   data_i     out  last correctly received byte (output despite its name)
//   rx_done    out  one-cycle pulse: data_i was updated this cycle
//   frame_err  out  one-cycle pulse: stop bit was sampled as 0
//   busy       out  high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data_i,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Start bit is sampled at its half-bit point; from there a full bit period
   // lands every later sample on the centre of its bit.
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   // Input path: two synchronizer flops plus one history flop for edge detect.
   logic sync1_q;
   logic rxd_s_q;
   logic rxd_d_q;

   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q,   cnt_d;
   logic [IW-1:0]        idx_q,   idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q,  data_d;
   logic                 done_q,  done_d;
   logic                 ferr_q,  ferr_d;

   logic fall_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rxd_s_q <= 1'b1;
         rxd_d_q <= 1'b1;
      end else begin
         sync1_q <= rxd;
         rxd_s_q <= sync1_q;
         rxd_d_q <= rxd_s_q;
      end
   end

   // Only a genuine 1->0 transition starts a frame; a line that is simply
   // sitting low (break, or after a framing error) never does.
   assign fall_edge = rxd_d_q & ~rxd_s_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (fall_edge) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rxd_s_q) begin
                  state_d = S_DATA;
                  idx_d   = '0;
               end else begin
                  // Line went back high before mid-start: treat as a glitch.
                  state_d = S_IDLE;
               end
            end
         end

         S_DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               // LSB arrives first, so shifting right leaves bit 0 at the LSB.
               shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
               idx_d   = idx_q + 1'b1;
               if (idx_q == LAST_BIT) begin
                  state_d = S_STOP;
               end
            end
         end

         S_STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d = '0;
               if (rxd_s_q) begin
                  data_d  = shift_q;
                  done_d  = 1'b1;
                  // Returning to idle at mid-stop lets the next start edge be
                  // caught even with no idle bits between frames.
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end
         end

         S_WAIT_HIGH: begin
            cnt_d = '0;
            if (rxd_s_q) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_i    = data_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   logic       clk;
   logic       rst;
   logic       line16;
   logic       line4;
   logic [7:0] data16, data4;
   logic       rx_done16, rx_done4;
   logic       frame_err16, frame_err4;
   logic       busy16, busy4;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // scoreboard: expected bytes pushed when a frame is driven
   logic [7:0] exp16_q[$];
   logic [7:0] exp4_q[$];

   int  done16_cnt = 0, ferr16_cnt = 0, done4_cnt = 0, ferr4_cnt = 0;
   int  last_done16 = 0, prev_done16 = 0, last_done4 = 0;
   int  start16 = 0, start4 = 0;
   bit  ignore16 = 1'b0;

   uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .rxd       (line16),
      .data_i    (data16),
      .rx_done   (rx_done16),
      .frame_err (frame_err16),
      .busy      (busy16)
   );

   uart_rx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .rxd       (line4),
      .data_i    (data4),
      .rx_done   (rx_done4),
      .frame_err (frame_err4),
      .busy      (busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Output monitor: pops the scoreboard on every rx_done pulse.
   always @(negedge clk) begin
      logic [7:0] e;
      if (rx_done16 || frame_err16) begin
         checks++;
         if (rx_done16 && frame_err16) begin
            failures++;
            $display("FAIL excl16: rx_done=%b frame_err=%b both high, required not both", rx_done16, frame_err16);
         end
      end
      if (rx_done16) begin
         done16_cnt++;
         prev_done16 = last_done16;
         last_done16 = cyc;
         if (!ignore16) begin
            checks++;
            if (exp16_q.size() == 0) begin
               failures++;
               $display("FAIL sb16_unexpected: rx_done with data=%02h, required no pulse", data16);
            end else begin
               e = exp16_q.pop_front();
               if (data16 !== e) begin
                  failures++;
                  $display("FAIL sb16_data: data_i=%02h required %02h", data16, e);
               end
            end
         end
         $display("rx16 byte=%02h cycle=%0d", data16, cyc);
      end
      if (frame_err16) ferr16_cnt++;
      if (rx_done4) begin
         done4_cnt++;
         last_done4 = cyc;
         checks++;
         if (exp4_q.size() == 0) begin
            failures++;
            $display("FAIL sb4_unexpected: rx_done with data=%02h, required no pulse", data4);
         end else begin
            e = exp4_q.pop_front();
            if (data4 !== e) begin
               failures++;
               $display("FAIL sb4_data: data_i=%02h required %02h", data4, e);
            end
         end
         $display("rx4 byte=%02h cycle=%0d", data4, cyc);
      end
      if (frame_err4) ferr4_cnt++;
   end

   // All driving happens at posedge+1 and each task returns aligned the same way.
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send16(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         line16 = f[i];
         if (i == 0) start16 = cyc;
         wait_cycles(16);
      end
   endtask

   task automatic send4(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         line4 = f[i];
         if (i == 0) start4 = cyc;
         wait_cycles(4);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; line16 = 1'b1; line4 = 1'b1;
      wait_cycles(3);
      checks++;
      if (data16 !== 8'h00 || rx_done16 !== 1'b0 || frame_err16 !== 1'b0 || busy16 !== 1'b0) begin
         failures++;
         $display("FAIL reset16: data=%02h done=%b ferr=%b busy=%b required 00 0 0 0", data16, rx_done16, frame_err16, busy16);
      end
      checks++;
      if (data4 !== 8'h00 || rx_done4 !== 1'b0 || frame_err4 !== 1'b0 || busy4 !== 1'b0) begin
         failures++;
         $display("FAIL reset4: data=%02h done=%b ferr=%b busy=%b required 00 0 0 0", data4, rx_done4, frame_err4, busy4);
      end
      rst = 1'b0;
      wait_cycles(4);
      $display("test_reset done");
   endtask

   task automatic test_single;
      int d0, f0, lat;
      d0 = done16_cnt; f0 = ferr16_cnt;
      exp16_q.push_back(8'hA5);
      send16(8'hA5, 1'b1);
      wait_cycles(16);
      lat = last_done16 - start16;
      checks++;
      if (done16_cnt - d0 !== 1) begin
         failures++;
         $display("FAIL single_pulses: got %0d rx_done pulses, required 1", done16_cnt - d0);
      end
      checks++;
      if (lat < 154 || lat > 156) begin
         failures++;
         $display("FAIL single_latency: latency=%0d required 155+-1", lat);
      end
      checks++;
      if (ferr16_cnt !== f0) begin
         failures++;
         $display("FAIL single_ferr: frame_err pulses=%0d required 0", ferr16_cnt - f0);
      end
      checks++;
      if (data16 !== 8'hA5) begin
         failures++;
         $display("FAIL single_data: data_i=%02h required a5", data16);
      end
      $display("test_single latency=%0d", lat);
   endtask

   task automatic test_back_to_back;
      int d0;
      d0 = done16_cnt;
      exp16_q.push_back(8'h00);
      exp16_q.push_back(8'hFF);
      send16(8'h00, 1'b1);
      send16(8'hFF, 1'b1);
      wait_cycles(16);
      checks++;
      if (done16_cnt - d0 !== 2) begin
         failures++;
         $display("FAIL b2b_pulses: got %0d rx_done pulses, required 2", done16_cnt - d0);
      end
      checks++;
      if (last_done16 - prev_done16 !== 160) begin
         failures++;
         $display("FAIL b2b_spacing: spacing=%0d required 160", last_done16 - prev_done16);
      end
      checks++;
      if (data16 !== 8'hFF) begin
         failures++;
         $display("FAIL b2b_data: data_i=%02h required ff", data16);
      end
      $display("test_back_to_back spacing=%0d", last_done16 - prev_done16);
   endtask

   task automatic test_glitch;
      int d0, f0;
      d0 = done16_cnt; f0 = ferr16_cnt;
      line16 = 1'b0;
      wait_cycles(4);
      checks++;
      if (busy16 !== 1'b1) begin
         failures++;
         $display("FAIL glitch_busy_high: busy=%b required 1", busy16);
      end
      line16 = 1'b1;
      wait_cycles(12);
      checks++;
      if (busy16 !== 1'b0) begin
         failures++;
         $display("FAIL glitch_busy_low: busy=%b required 0", busy16);
      end
      checks++;
      if (done16_cnt !== d0 || ferr16_cnt !== f0) begin
         failures++;
         $display("FAIL glitch_pulses: done=%0d ferr=%0d required 0 0", done16_cnt - d0, ferr16_cnt - f0);
      end
      wait_cycles(16);
      $display("test_glitch done");
   endtask

   task automatic test_frame_err;
      int d0, f0;
      d0 = done16_cnt; f0 = ferr16_cnt;
      send16(8'h55, 1'b0);
      wait_cycles(40);
      checks++;
      if (ferr16_cnt - f0 !== 1) begin
         failures++;
         $display("FAIL ferr_pulses: frame_err pulses=%0d required 1", ferr16_cnt - f0);
      end
      checks++;
      if (done16_cnt !== d0) begin
         failures++;
         $display("FAIL ferr_done: rx_done pulses=%0d required 0", done16_cnt - d0);
      end
      checks++;
      if (data16 !== 8'hFF) begin
         failures++;
         $display("FAIL ferr_data: data_i=%02h required ff", data16);
      end
      checks++;
      if (busy16 !== 1'b1) begin
         failures++;
         $display("FAIL ferr_wait_busy: busy=%b required 1", busy16);
      end
      line16 = 1'b1;
      wait_cycles(16);
      checks++;
      if (busy16 !== 1'b0) begin
         failures++;
         $display("FAIL ferr_idle: busy=%b required 0", busy16);
      end
      exp16_q.push_back(8'h3C);
      send16(8'h3C, 1'b1);
      wait_cycles(16);
      checks++;
      if (done16_cnt - d0 !== 1 || data16 !== 8'h3C) begin
         failures++;
         $display("FAIL ferr_recover: pulses=%0d data_i=%02h required 1 3c", done16_cnt - d0, data16);
      end
      $display("test_frame_err done");
   endtask

   task automatic test_reset_mid;
      logic [9:0] f;
      int d0;
      f = {1'b1, 8'h96, 1'b0};
      d0 = done16_cnt;
      for (int i = 0; i < 10; i++) begin
         line16 = f[i];
         if (i == 5) begin
            wait_cycles(8);
            rst = 1'b1;
            #1;
            checks++;
            if (data16 !== 8'h00 || rx_done16 !== 1'b0 || frame_err16 !== 1'b0 || busy16 !== 1'b0) begin
               failures++;
               $display("FAIL rstmid_outputs: data=%02h done=%b ferr=%b busy=%b required 00 0 0 0", data16, rx_done16, frame_err16, busy16);
            end
            // The later falling edge of this frame may start a bogus frame
            // that completes after the original stop bit; it is not scored.
            ignore16 = 1'b1;
            wait_cycles(1);
            rst = 1'b0;
            wait_cycles(7);
         end else begin
            wait_cycles(16);
         end
      end
      checks++;
      if (done16_cnt !== d0) begin
         failures++;
         $display("FAIL rstmid_nodone: rx_done pulses=%0d required 0", done16_cnt - d0);
      end
      wait_cycles(192);
      ignore16 = 1'b0;
      d0 = done16_cnt;
      exp16_q.push_back(8'h3C);
      send16(8'h3C, 1'b1);
      wait_cycles(16);
      checks++;
      if (done16_cnt - d0 !== 1 || data16 !== 8'h3C) begin
         failures++;
         $display("FAIL rstmid_recover: pulses=%0d data_i=%02h required 1 3c", done16_cnt - d0, data16);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_fast;
      int d0, lat;
      d0 = done4_cnt;
      exp4_q.push_back(8'h81);
      send4(8'h81);
      wait_cycles(8);
      lat = last_done4 - start4;
      checks++;
      if (done4_cnt - d0 !== 1) begin
         failures++;
         $display("FAIL fast_pulses: got %0d rx_done pulses, required 1", done4_cnt - d0);
      end
      checks++;
      if (lat < 40 || lat > 42) begin
         failures++;
         $display("FAIL fast_latency: latency=%0d required 41+-1", lat);
      end
      checks++;
      if (data4 !== 8'h81) begin
         failures++;
         $display("FAIL fast_data: data_i=%02h required 81", data4);
      end
      $display("test_fast latency=%0d", lat);
   endtask

   task automatic test_drain;
      checks++;
      if (exp16_q.size() != 0 || exp4_q.size() != 0) begin
         failures++;
         $display("FAIL drain: pending expected bytes %0d/%0d required 0/0", exp16_q.size(), exp4_q.size());
      end
      checks++;
      if (ferr4_cnt != 0) begin
         failures++;
         $display("FAIL fast_ferr: frame_err pulses=%0d required 0", ferr4_cnt);
      end
   endtask

   initial begin
      rst = 1'b1; line16 = 1'b1; line4 = 1'b1;
      #1;
      test_reset;
      test_single;
      test_back_to_back;
      test_glitch;
      test_frame_err;
      test_reset_mid;
      test_fast;
      test_drain;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
